periph_bus_bridge: RTL and testbench

//  Upstream master of the peripheral bus: turns CPU data-port loads/stores that hit
//  the peripheral window into addr/data/read/write transactions on the peripheral bus.

---
 rtl/periph_bus_bridge.sv | 151 +++++++++++++++
 tb/tb_periph_bus_bridge.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : periph_bus_bridge
// Brief    : CPU data-port to peripheral bus master with stall and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module periph_bus_bridge #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 4,
    parameter int          DEV_BITS   = 2,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          TIMEOUT    = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    input  logic                     cpu_rd,
    input  logic                     cpu_wr,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     cpu_stall,
    output logic                     err,
    input  logic                     err_clr,
    output logic [ADDR_WIDTH-1:0]    p_addr,
    inout  wire  [DATA_WIDTH-1:0]    p_data,
    output logic                     p_read,
    output logic                     p_write,
    output logic [2**DEV_BITS-1:0]   p_sel,
    input  logic                     p_ready
);

    localparam int         c_W         = ADDR_WIDTH + DEV_BITS + 2;
    localparam int         c_DEV_COUNT = 2**DEV_BITS;
    localparam logic [7:0] c_TIMEOUT   = 8'(TIMEOUT);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_STROBE = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [DEV_BITS-1:0]   r_dev;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_is_wr;
    logic [7:0]            r_cnt;
    logic                  r_err;
    logic                  w_hit;
    logic                  w_req;
    logic                  w_timeout;
    logic                  w_drive;
    logic                  w_unused;

    assign w_hit     = (cpu_addr[31:c_W] == BASE_ADDR[31:c_W]);
    assign w_req     = w_hit & (cpu_rd | cpu_wr);
    // Ready in the final counted cycle still completes the access normally.
    assign w_timeout = (r_state == c_ST_STROBE) && !p_ready && (r_cnt == c_TIMEOUT);
    assign w_unused  = ^cpu_addr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_req) w_next = c_ST_SETUP;
            c_ST_SETUP:  w_next = c_ST_STROBE;
            c_ST_STROBE: if (p_ready || w_timeout) w_next = c_ST_DONE;
            default:     w_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        p_addr    = '0;
        p_sel     = '0;
        p_read    = 1'b0;
        p_write   = 1'b0;
        w_drive   = 1'b0;
        cpu_stall = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                cpu_stall = w_req;
            end
            c_ST_SETUP, c_ST_STROBE: begin
                p_addr    = r_idx;
                p_sel     = {{(c_DEV_COUNT-1){1'b0}}, 1'b1} << r_dev;
                p_read    = (r_state == c_ST_STROBE) && !r_is_wr;
                p_write   = (r_state == c_ST_STROBE) && r_is_wr;
                w_drive   = r_is_wr;
                cpu_stall = 1'b1;
            end
            default: begin
                cpu_stall = 1'b0;
            end
        endcase
    end

    assign p_data = w_drive ? r_wdata : {DATA_WIDTH{1'bz}};
    assign err    = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_dev     <= '0;
            r_wdata   <= '0;
            r_is_wr   <= 1'b0;
            r_cnt     <= '0;
            cpu_rdata <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_req) begin
                        r_idx   <= cpu_addr[ADDR_WIDTH+1:2];
                        r_dev   <= cpu_addr[c_W-1:ADDR_WIDTH+2];
                        r_wdata <= cpu_wdata;
                        r_is_wr <= cpu_wr;
                    end
                end
                c_ST_SETUP: begin
                    r_cnt <= 8'd1;
                end
                c_ST_STROBE: begin
                    if (p_ready) begin
                        if (!r_is_wr) cpu_rdata <= p_data;
                    end else if (w_timeout) begin
                        cpu_rdata <= '1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_periph_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_periph_bus_bridge
// Brief    : Self-checking bench for periph_bus_bridge with a device model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_periph_bus_bridge;

    localparam logic [31:0] c_SENT = 32'hA5A5_5A5A;
    localparam int          c_TO   = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        err;
    logic        err_clr;
    logic [3:0]  p_addr;
    wire  [31:0] p_data;
    logic        p_read;
    logic        p_write;
    logic [3:0]  p_sel;
    logic        p_ready;

    int checks   = 0;
    int failures = 0;

    int          cfg_delay = 0;
    int          scnt;
    logic        sent_en = 1'b0;
    logic [31:0] dev_mem [4][16];

    always #5 clk = ~clk;

    periph_bus_bridge dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .err(err), .err_clr(err_clr), .p_addr(p_addr),
        .p_data(p_data), .p_read(p_read), .p_write(p_write), .p_sel(p_sel),
        .p_ready(p_ready)
    );

    function automatic logic [31:0] init_val(int d, int r);
        if (d == 1 && r == 3) return 32'h1234_5678;
        return 32'hC0DE_0000 | (d << 8) | r;
    endfunction

    function automatic int sel2dev(logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s[i]) return i;
        return 0;
    endfunction

    // Device side: answers after cfg_delay strobe cycles (0 = never).
    always @(posedge clk) begin
        if (rst) scnt <= 0;
        else if (p_read || p_write) scnt <= scnt + 1;
        else scnt <= 0;
    end

    assign p_ready = (p_read || p_write) && (cfg_delay != 0) && (scnt + 1 == cfg_delay);
    assign p_data  = sent_en ? c_SENT : (p_read ? dev_mem[sel2dev(p_sel)][p_addr] : 32'hzzzz_zzzz);

    always @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < 4; d++)
                for (int r = 0; r < 16; r++) dev_mem[d][r] <= init_val(d, r);
        end else if (p_write && p_ready) begin
            dev_mem[sel2dev(p_sel)][p_addr] <= p_data;
        end
    end

    // Reference model state: what the CPU should observe.
    logic [31:0] ref_mem [4][16];
    logic [31:0] ref_rdata;
    logic        ref_err;

    task automatic model_reset();
        for (int d = 0; d < 4; d++)
            for (int r = 0; r < 16; r++) ref_mem[d][r] = init_val(d, r);
        ref_rdata = 32'h0;
        ref_err   = 1'b0;
    endtask

    task automatic model_step(input logic [31:0] addr, input bit rd, input bit wr,
                              input logic [31:0] wd, input int dly,
                              output int e_stall, output int e_strobe);
        bit hit = (addr[31:8] == 24'hFFFF00);
        int dev = (addr >> 6) & 3;
        int idx = (addr >> 2) & 15;
        bit ok  = (dly >= 1) && (dly <= c_TO);
        e_stall  = 0;
        e_strobe = 0;
        if (hit && (rd || wr)) begin
            e_strobe = ok ? dly : c_TO;
            e_stall  = 2 + e_strobe;
            if (!ok) begin
                ref_rdata = 32'hFFFF_FFFF;
                ref_err   = 1'b1;
            end else if (wr) begin
                ref_mem[dev][idx] = wd;
            end else begin
                ref_rdata = ref_mem[dev][idx];
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_undriven(input string name);
        sent_en = 1'b1;
        #1;
        chk(name, p_data, c_SENT);
        sent_en = 1'b0;
    endtask

    // One CPU access from the IDLE cycle through the cycle where stall drops.
    task automatic access(input logic [31:0] addr, input bit rd, input bit wr,
                          input logic [31:0] wd, input int dly,
                          input int e_stall, input int e_strobe,
                          input logic [31:0] e_rdata, input bit e_err);
        int  stall_n  = 0;
        int  strobe_n = 0;
        bit  done     = 0;
        bit  bus_ok   = 1;
        logic [3:0] e_sel = 4'b0001 << ((addr >> 6) & 3);
        logic [3:0] e_idx = 4'((addr >> 2) & 15);
        cfg_delay = dly;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            cpu_addr = addr; cpu_rd = rd; cpu_wr = wr; cpu_wdata = wd;
            #1;
            if (!cpu_stall) begin
                done = 1;
                break;
            end
            stall_n++;
            if (p_read || p_write) strobe_n++;
            if (cyc > 0) begin
                if (p_sel !== e_sel || p_addr !== e_idx) bus_ok = 0;
                if ((p_read || p_write) && (p_write !== wr || p_read !== !wr)) bus_ok = 0;
                if (wr && p_data !== wd) bus_ok = 0;
            end
        end
        chk("stall_bound", 32'(done), 32'd1);
        chk("stall_cycles", stall_n, e_stall);
        chk("strobe_cycles", strobe_n, e_strobe);
        chk("bus_fields", 32'(bus_ok), 32'd1);
        chk("done_sel", {p_read, p_write, p_sel}, 6'b0);
        chk("done_rdata", cpu_rdata, e_rdata);
        chk("done_err", 32'(err), 32'(e_err));
        chk_undriven("done_bus_z");
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          rd;
        bit          wr;
        logic [31:0] wd;
        int          dly;
        int          e_stall;
        int          e_strobe;
        logic [31:0] e_rdata;
        bit          e_err;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int es, eb;
        vecs[0] = '{32'hFFFF_004C, 1, 0, 32'h0,         1,  3,  1, 32'h1234_5678, 0};
        vecs[1] = '{32'hFFFF_000C, 0, 1, 32'h8000_00FF, 1,  3,  1, 32'h1234_5678, 0};
        vecs[2] = '{32'hFFFF_000C, 1, 0, 32'h0,         5,  7,  5, 32'h8000_00FF, 0};
        vecs[3] = '{32'hFFFF_0080, 1, 0, 32'h0,         0, 17, 15, 32'hFFFF_FFFF, 1};
        vecs[4] = '{32'h0000_1000, 1, 0, 32'h0,         1,  0,  0, 32'hFFFF_FFFF, 1};
        vecs[5] = '{32'hFFFF_00FC, 1, 0, 32'h0,        15, 17, 15, 32'hC0DE_030F, 1};
        vecs[6] = '{32'hFFFF_0044, 1, 1, 32'hAAAA_5555, 2,  4,  2, 32'hC0DE_030F, 1};
        vecs[7] = '{32'hFFFF_0044, 1, 0, 32'h0,         3,  5,  3, 32'hAAAA_5555, 1};
        vecs[8] = '{32'hFFFF_00C8, 0, 1, 32'h1111_2222,16, 17, 15, 32'hFFFF_FFFF, 1};

        rst = 1'b1; cpu_addr = 0; cpu_wdata = 0; cpu_rd = 0; cpu_wr = 0; err_clr = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_outputs", {cpu_stall, err, p_read, p_write, p_sel, p_addr}, 12'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk_undriven("rst_bus_z");
        rst = 1'b0;

        foreach (vecs[i]) begin
            access(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wd, vecs[i].dly,
                   vecs[i].e_stall, vecs[i].e_strobe, vecs[i].e_rdata, vecs[i].e_err);
            model_step(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wd, vecs[i].dly, es, eb);
        end

        // Sticky error cleared by err_clr.
        @(negedge clk);
        cpu_rd = 0; cpu_wr = 0; err_clr = 1'b1;
        #1;
        chk("err_before_clr", 32'(err), 32'd1);
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk("err_after_clr", 32'(err), 32'd0);
        ref_err = 1'b0;

        // Reset while a read is in its strobe phase.
        cfg_delay = 0;
        @(negedge clk);
        cpu_addr = 32'hFFFF_0014; cpu_rd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_strobe_read", 32'(p_read), 32'd1);
        @(negedge clk);
        rst = 1'b1; cpu_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_outputs", {cpu_stall, err, p_read, p_write, p_sel, p_addr}, 12'h0);
        chk("mid_rst_rdata", cpu_rdata, 32'h0);
        chk_undriven("mid_rst_bus_z");
        model_reset();

        access(32'hFFFF_0014, 1, 0, 32'h0, 2, 4, 2, init_val(0, 5), 0);
        model_step(32'hFFFF_0014, 1, 0, 32'h0, 2, es, eb);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, wd;
            bit rd, wr;
            int dly;
            a   = ($urandom_range(0, 9) == 0) ? ($urandom & 32'h0FFF_FFFF)
                                               : (32'hFFFF_0000 | ($urandom & 32'hFF));
            rd  = 1'($urandom);
            wr  = 1'($urandom);
            wd  = $urandom;
            dly = $urandom_range(0, 17);
            model_step(a, rd, wr, wd, dly, es, eb);
            access(a, rd, wr, wd, dly, es, eb, ref_rdata, ref_err);
        end

        @(negedge clk);
        cpu_rd = 0; cpu_wr = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
